// File: rtl/pacman_space_responder.sv
// pacman_space_responder
//   Fabric-side responder for the HPS command path. Software writes a 16-bit
//   command word on the pacman PIO and watches the space PIO for a response.
//   A command is new when its req toggle differs from the current ack toggle.
//   The block owns a maze tile RAM (2 bits per tile, address = {row, col}).
//   It answers tile queries, neighbour lookups, writes, bulk clears and
//   pellet counts.
//
// Ports
//   clk_clk      in   1   system clock (same clock as the PIO cores)
//   reset_reset  in   1   asynchronous active-high reset
//   cmd_export   in  16   [15] req toggle, [14:12] opcode, [11:0] payload
//   rsp_export   out 16   [15] ack toggle, [14] error, [13:12] 0, [11:0] data
//   busy         out  1   high whenever the FSM is not idle
//
// Build option
//   PACMAN_PELLET_COUNT_EN : when defined, keeps a running pellet count and
//   implements opcode 6 (COUNT). When undefined, opcode 6 returns an error.
module pacman_space_responder #(
  parameter int MAZE_COLS = 28,
  parameter int MAZE_ROWS = 31
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [15:0] cmd_export,
  output logic [15:0] rsp_export,
  output logic        busy
);
  localparam int         DEPTH     = MAZE_ROWS * 32;
  localparam logic [5:0] COLS_W    = 6'(MAZE_COLS);
  localparam logic [5:0] ROWS_W    = 6'(MAZE_ROWS);
  localparam logic [4:0] LAST_COL  = 5'(MAZE_COLS - 1);
  localparam logic [4:0] LAST_ROW  = 5'(MAZE_ROWS - 1);
  localparam logic [9:0] LAST_ADDR = 10'(DEPTH - 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_SET_ROW = 3'd1;
  localparam logic [2:0] OP_QUERY   = 3'd2;
  localparam logic [2:0] OP_WRITE   = 3'd3;
  localparam logic [2:0] OP_DIR     = 3'd4;
  localparam logic [2:0] OP_CLEAR   = 3'd5;
  localparam logic [2:0] OP_COUNT   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_READ, S_RESP, S_CLEAR
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] cmd_q;
  logic        tog_reg;
  logic [2:0]  op_reg;
  logic [6:0]  arg_reg;
  logic [4:0]  row_reg;
  logic [9:0]  addr_reg;
  logic [4:0]  ncol_reg;
  logic        err_reg;
  logic [9:0]  clr_addr_reg;
  logic [15:0] rsp_reg;
  logic [1:0]  rd_reg;
  logic        accept;
  logic [4:0]  a_row, a_col;
  logic        a_err;
  logic        rsp_err;
  logic [11:0] rsp_data;
  logic        ram_we;
  logic [9:0]  ram_waddr;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram [DEPTH];

`ifdef PACMAN_PELLET_COUNT_EN
  localparam logic [11:0] FULL_CNT = 12'(MAZE_ROWS * MAZE_COLS);
  logic [11:0] pellet_cnt_reg;
`endif

  // Payload bits above the tile/dir field carry nothing for any opcode.
  logic unused_payload;
  assign unused_payload = ^cmd_q[11:7];

  assign accept     = (state_reg == S_IDLE) && (cmd_q[15] != rsp_reg[15]);
  assign busy       = (state_reg != S_IDLE);
  assign rsp_export = rsp_reg;

  // State register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state_reg <= S_IDLE;
    else             state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          case (cmd_q[14:12])
            OP_QUERY, OP_WRITE, OP_DIR: state_next = S_ADDR;
            OP_CLEAR:                   state_next = S_CLEAR;
            default:                    state_next = S_RESP;
          endcase
        end
      end
      S_ADDR:  state_next = S_READ;
      S_READ:  state_next = S_RESP;
      S_CLEAR: if (clr_addr_reg == LAST_ADDR) state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Target tile for QUERY/WRITE/QUERY_DIR. Horizontal moves wrap through
  // the tunnel; vertical moves off the maze edge are errors.
  always_comb begin
    a_row = row_reg;
    a_col = arg_reg[4:0];
    a_err = ({1'b0, arg_reg[4:0]} >= COLS_W);
    if (op_reg == OP_DIR) begin
      case (arg_reg[6:5])
        2'd0: if (row_reg == 5'd0) a_err = 1'b1; else a_row = row_reg - 5'd1;
        2'd1: if (row_reg == LAST_ROW) a_err = 1'b1; else a_row = row_reg + 5'd1;
        2'd2: a_col = (arg_reg[4:0] == 5'd0) ? LAST_COL : arg_reg[4:0] - 5'd1;
        default: a_col = (arg_reg[4:0] == LAST_COL) ? 5'd0 : arg_reg[4:0] + 5'd1;
      endcase
    end
  end

  // Response fields, consumed only in S_RESP.
  always_comb begin
    rsp_err  = 1'b0;
    rsp_data = '0;
    case (op_reg)
      OP_NOP, OP_CLEAR: rsp_data = '0;
      OP_SET_ROW:       rsp_err = ({1'b0, arg_reg[4:0]} >= ROWS_W);
      OP_QUERY, OP_WRITE: begin
        rsp_err = err_reg;
        if (!err_reg) rsp_data = {10'd0, rd_reg};
      end
      OP_DIR: begin
        rsp_err = err_reg;
        if (!err_reg) rsp_data = {ncol_reg, 5'd0, rd_reg};
      end
`ifdef PACMAN_PELLET_COUNT_EN
      OP_COUNT:         rsp_data = pellet_cnt_reg;
`endif
      default:          rsp_err = 1'b1;
    endcase
  end

  // RAM write port. CLEAR writes address 0 on the accept edge so the
  // remaining addresses stream out of S_CLEAR one per cycle.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_addr_reg;
    ram_wdata = arg_reg[1:0];
    if (accept && (cmd_q[14:12] == OP_CLEAR)) begin
      ram_we    = 1'b1;
      ram_waddr = '0;
      ram_wdata = cmd_q[1:0];
    end else if (state_reg == S_CLEAR) begin
      ram_we = 1'b1;
    end else if ((state_reg == S_RESP) && (op_reg == OP_WRITE) && !err_reg) begin
      ram_we    = 1'b1;
      ram_waddr = addr_reg;
      ram_wdata = arg_reg[6:5];
    end
  end

  // Tile RAM: contents are deliberately not reset.
  always_ff @(posedge clk_clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    rd_reg <= ram[addr_reg];
  end

  // Datapath registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cmd_q        <= '0;
      tog_reg      <= 1'b0;
      op_reg       <= '0;
      arg_reg      <= '0;
      row_reg      <= '0;
      addr_reg     <= '0;
      ncol_reg     <= '0;
      err_reg      <= 1'b0;
      clr_addr_reg <= '0;
      rsp_reg      <= '0;
    end else begin
      cmd_q <= cmd_export;
      if (accept) begin
        tog_reg      <= cmd_q[15];
        op_reg       <= cmd_q[14:12];
        arg_reg      <= cmd_q[6:0];
        clr_addr_reg <= 10'd1;
      end
      if (state_reg == S_CLEAR) clr_addr_reg <= clr_addr_reg + 10'd1;
      if (state_reg == S_ADDR) begin
        addr_reg <= {a_row, a_col};
        ncol_reg <= a_col;
        err_reg  <= a_err;
      end
      if (state_reg == S_RESP) begin
        rsp_reg <= {tog_reg, rsp_err, 2'b00, rsp_data};
        if ((op_reg == OP_SET_ROW) && !rsp_err) row_reg <= arg_reg[4:0];
      end
    end
  end

`ifdef PACMAN_PELLET_COUNT_EN
  // Running pellet count: CLEAR sets it, WRITE adjusts it from the old
  // tile (read back before the write) and the new one. Tile codes 2/3 are
  // pellets, so bit 1 is the pellet flag.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      pellet_cnt_reg <= '0;
    end else if (state_reg == S_RESP) begin
      if (op_reg == OP_CLEAR) begin
        pellet_cnt_reg <= arg_reg[1] ? FULL_CNT : 12'd0;
      end else if ((op_reg == OP_WRITE) && !err_reg) begin
        if (!rd_reg[1] && arg_reg[6] && (pellet_cnt_reg != 12'hFFF))
          pellet_cnt_reg <= pellet_cnt_reg + 12'd1;
        else if (rd_reg[1] && !arg_reg[6] && (pellet_cnt_reg != 12'd0))
          pellet_cnt_reg <= pellet_cnt_reg - 12'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pacman_space_responder.sv
// Directed testbench for pacman_space_responder. Works with or without
// PACMAN_PELLET_COUNT_EN; COUNT expectations follow the build option.
module tb_pacman_space_responder;
  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [15:0] cmd_export;
  logic [15:0] rsp_export;
  logic        busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic tog     = 1'b0;

  always #5 clk_clk = ~clk_clk;

  pacman_space_responder dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .cmd_export  (cmd_export),
    .rsp_export  (rsp_export),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rsp_w(input logic e, input logic [11:0] d);
    return {tog, e, 2'b00, d};
  endfunction

  // Expected COUNT response for a given pellet count.
  function automatic logic [15:0] cnt_exp(input int n);
`ifdef PACMAN_PELLET_COUNT_EN
    return rsp_w(1'b0, 12'(n));
`else
    return rsp_w(1'b1, 12'(n - n));
`endif
  endfunction

  // Issue one command with a fresh toggle and wait (bounded) for its ack.
  // cyc counts clock edges from driving the word to seeing the ack.
  task automatic do_cmd(input logic [2:0] op, input logic [11:0] pl,
                        output logic [15:0] rsp, output int cyc);
    tog = ~tog;
    cmd_export = {tog, op, pl};
    cyc = 0;
    do begin
      @(posedge clk_clk); #1;
      cyc++;
    end while ((rsp_export[15] !== tog) && (cyc < 3000));
    if (rsp_export[15] !== tog) check("ack_timeout", {15'd0, rsp_export[15]}, {15'd0, tog});
    rsp = rsp_export;
    $display("[TB] cmd 0x%04h -> rsp 0x%04h after %0d cycles", cmd_export, rsp, cyc);
  endtask

  // Issue a command and compare its response and, if lat > 0, its latency.
  task automatic cmd_chk(input string tag, input logic [2:0] op, input logic [11:0] pl,
                         input logic e, input logic [11:0] d, input int lat);
    logic [15:0] r;
    int          c;
    do_cmd(op, pl, r, c);
    check(tag, r, rsp_w(e, d));
    if (lat > 0) check({tag, "_lat"}, 16'(c), 16'(lat));
  endtask

  task automatic count_chk(input string tag, input int n);
    logic [15:0] r;
    int          c;
    do_cmd(3'd6, 12'h000, r, c);
    check(tag, r, cnt_exp(n));
  endtask

  initial begin
    int busy_cyc;
    int cyc;

    // Reset state
    reset_reset = 1'b1;
    cmd_export  = 16'h0000;
    repeat (3) @(posedge clk_clk);
    #1;
    check("reset_rsp", rsp_export, 16'h0000);
    check("reset_busy", {15'd0, busy}, 16'h0000);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1;

    // NOP: registered into cmd_q, accepted next edge, ack one cycle later
    tog = 1'b1;
    cmd_export = 16'h8000;
    @(posedge clk_clk); #1;
    check("nop_cmdq_rsp", rsp_export, 16'h0000);
    check("nop_cmdq_busy", {15'd0, busy}, 16'h0000);
    @(posedge clk_clk); #1;
    check("nop_accept_rsp", rsp_export, 16'h0000);
    check("nop_accept_busy", {15'd0, busy}, 16'h0001);
    @(posedge clk_clk); #1;
    check("nop_ack_rsp", rsp_export, 16'h8000);
    check("nop_ack_busy", {15'd0, busy}, 16'h0000);
    $display("[TB] cmd 0x8000 -> rsp 0x%04h", rsp_export);

    // CLEAR fill=2 with a COUNT toggled in while busy
    tog = 1'b0;
    cmd_export = 16'h5002;
    busy_cyc = 0;
    cyc = 0;
    while (cyc < 3000) begin
      @(posedge clk_clk); #1;
      cyc++;
      if (busy) busy_cyc++;
      if (cyc == 100) cmd_export = 16'hE000;
      if (rsp_export[15] == 1'b0) break;
    end
    $display("[TB] cmd 0x5002 -> rsp 0x%04h after %0d cycles, busy %0d", rsp_export, cyc, busy_cyc);
    check("clear_rsp", rsp_export, 16'h0000);
    check("clear_busy_cycles", 16'(busy_cyc), 16'd992);
    check("clear_lat", 16'(cyc), 16'd994);
    tog = 1'b1;
    @(posedge clk_clk); #1;
    check("pending_accept_busy", {15'd0, busy}, 16'h0001);
    check("pending_accept_rsp", rsp_export, 16'h0000);
    @(posedge clk_clk); #1;
    check("pending_count", rsp_export, cnt_exp(868));
    $display("[TB] cmd 0xE000 (queued) -> rsp 0x%04h", rsp_export);

    // Row latch, write, query, count
    cmd_chk("set_row5", 3'd1, 12'h005, 1'b0, 12'h000, 3);
    cmd_chk("write_5_3_wall", 3'd3, 12'h023, 1'b0, 12'h002, 5);
    cmd_chk("query_5_3", 3'd2, 12'h003, 1'b0, 12'h001, 5);
    count_chk("count_after_wall", 867);
    cmd_chk("write_5_27_power", 3'd3, 12'h07B, 1'b0, 12'h002, 5);
    count_chk("count_pellet_to_power", 867);

    // Neighbour lookups, including tunnel wrap and vertical edges
    cmd_chk("dir_left_wrap", 3'd4, 12'h040, 1'b0, 12'hD83, 5);
    cmd_chk("dir_right_wrap", 3'd4, 12'h07B, 1'b0, 12'h002, 5);
    cmd_chk("dir_up_5_3", 3'd4, 12'h003, 1'b0, 12'h182, 5);
    cmd_chk("dir_down_5_3", 3'd4, 12'h023, 1'b0, 12'h182, 5);
    cmd_chk("set_row0", 3'd1, 12'h000, 1'b0, 12'h000, 0);
    cmd_chk("dir_up_row0", 3'd4, 12'h003, 1'b1, 12'h000, 5);
    cmd_chk("set_row30", 3'd1, 12'h01E, 1'b0, 12'h000, 0);
    cmd_chk("dir_down_row30", 3'd4, 12'h023, 1'b1, 12'h000, 5);
    cmd_chk("dir_up_row30", 3'd4, 12'h003, 1'b0, 12'h182, 0);

    // Column / row range errors
    cmd_chk("query_col28", 3'd2, 12'h01C, 1'b1, 12'h000, 5);
    cmd_chk("set_row5b", 3'd1, 12'h005, 1'b0, 12'h000, 0);
    cmd_chk("set_row31", 3'd1, 12'h01F, 1'b1, 12'h000, 3);
    cmd_chk("query_after_bad_row", 3'd2, 12'h003, 1'b0, 12'h001, 0);
    cmd_chk("write_col28", 3'd3, 12'h01C, 1'b1, 12'h000, 5);
    count_chk("count_after_bad_write", 867);
    cmd_chk("write_5_3_pellet", 3'd3, 12'h043, 1'b0, 12'h001, 0);
    count_chk("count_after_pellet", 868);
    cmd_chk("opcode7", 3'd7, 12'hABC, 1'b1, 12'h000, 3);
    cmd_chk("nop_payload", 3'd0, 12'h123, 1'b0, 12'h000, 3);

    // CLEAR with fill 0
    cmd_chk("clear_fill0", 3'd5, 12'h000, 1'b0, 12'h000, 994);
    count_chk("count_after_clear0", 0);
    cmd_chk("query_after_clear0", 3'd2, 12'h003, 1'b0, 12'h000, 0);

    // Reset in the middle of a CLEAR fill=2
    tog = ~tog;
    cmd_export = {tog, 3'd5, 12'h002};
    repeat (50) @(posedge clk_clk);
    #1;
    check("midclear_busy", {15'd0, busy}, 16'h0001);
    reset_reset = 1'b1;
    #1;
    check("midclear_reset_rsp", rsp_export, 16'h0000);
    check("midclear_reset_busy", {15'd0, busy}, 16'h0000);
    $display("[TB] reset during CLEAR -> rsp 0x%04h busy %0b", rsp_export, busy);
    cmd_export = 16'h0000;
    tog = 1'b0;
    repeat (2) @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    repeat (3) @(posedge clk_clk);
    #1;
    check("post_reset_no_ack", rsp_export, 16'h0000);

    // Partially cleared RAM stays as is; row latch and count are reset
    cmd_chk("query_0_0_cleared", 3'd2, 12'h000, 1'b0, 12'h002, 5);
    cmd_chk("set_row5c", 3'd1, 12'h005, 1'b0, 12'h000, 0);
    cmd_chk("query_5_3_untouched", 3'd2, 12'h003, 1'b0, 12'h000, 0);
    count_chk("count_after_reset", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
